// File: rtl/wave_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// wave_sequencer_pkg
// Shared types and constants for the wave sequencer and its tick generator:
//   - seq_state_t  : playback FSM states (idle, playing, one-cycle done)
//   - step_entry_t : one step-table entry {mask, scale, dur}
//   - width constants for the table fields and the step index / step count
//   - effDur()     : duration in ticks actually played (a zero duration plays
//                    as one tick)
// ----------------------------------------------------------------------------
package wave_sequencer_pkg;

    localparam int MASK_W  = 4;
    localparam int SCALE_W = 6;
    localparam int DUR_W   = 8;
    localparam int IDX_W   = 3;
    localparam int NSTEP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [MASK_W-1:0]  mask;
        logic [SCALE_W-1:0] scale;
        logic [DUR_W-1:0]   dur;
    } step_entry_t;

    // Every table entry comes out of reset silent, with a one-tick duration
    localparam step_entry_t ENTRY_RESET = '{mask: '0, scale: '0, dur: 8'd1};

    function automatic logic [DUR_W-1:0] effDur(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/wave_sequencer_tick.sv
// ----------------------------------------------------------------------------
// seq_tick_gen
// Duration-tick prescaler. A down-counter that reads zero once every TICK_DIV
// cycles; o_tick is high in that cycle. i_clear reloads the counter so that
// the first tick after a step load lands exactly TICK_DIV cycles later.
//   sysclk   in  clock
//   sysrst_n in  asynchronous active-low reset (counter forced to 0)
//   i_clear  in  reload the prescaler (step load, or not playing)
//   o_tick   out one-cycle duration tick
// ----------------------------------------------------------------------------
module seq_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Counts TICK_DIV-1 down to 0 and reloads; a clear restarts the period.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == '0)) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Not gated by i_clear: the clear itself depends on the tick at step end.
    assign o_tick = (r_count == '0);

endmodule

// File: rtl/wave_sequencer.sv
// ----------------------------------------------------------------------------
// wave_sequencer
// Plays a programmable table of steps into a summing synthesizer. Each step
// holds a generator enable mask and an amplitude scale for dur*TICK_DIV
// cycles; steps follow each other with no gap, optionally looping.
//   sysclk, sysrst_n              clock, async active-low reset
//   wr_en/wr_addr/wr_mask/
//   wr_scale/wr_dur               table write port (accepted only in IDLE)
//   wr_ready                      high while writes are accepted
//   start/stop/loop_en/num_steps  playback control
//   Enable_SW, Scale              registered synthesizer controls
//   busy, step_idx, done          playback status
// ----------------------------------------------------------------------------
module wave_sequencer
    import wave_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int DEPTH    = 8
) (
    input  logic               sysclk,
    input  logic               sysrst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [MASK_W-1:0]  wr_mask,
    input  logic [SCALE_W-1:0] wr_scale,
    input  logic [DUR_W-1:0]   wr_dur,
    output logic               wr_ready,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [NSTEP_W-1:0] num_steps,
    output logic [MASK_W-1:0]  Enable_SW,
    output logic [SCALE_W-1:0] Scale,
    output logic               busy,
    output logic [IDX_W-1:0]   step_idx,
    output logic               done
);

    localparam logic [NSTEP_W:0] DEPTH_N = (NSTEP_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_A = (IDX_W + 1)'(DEPTH);

    seq_state_t         r_state;
    seq_state_t         w_stateNext;
    step_entry_t        r_table [DEPTH];
    logic [MASK_W-1:0]  r_enable;
    logic [SCALE_W-1:0] r_scale;
    logic [IDX_W-1:0]   r_stepIdx;
    logic [DUR_W-1:0]   r_durCnt;
    logic [NSTEP_W-1:0] r_numSteps;

    logic               w_tick;
    logic               w_tickClear;
    logic               w_load;
    logic [IDX_W-1:0]   w_loadIdx;
    logic               w_startOk;
    logic               w_stepEnd;
    logic               w_lastStep;
    step_entry_t        w_entry;

    assign w_startOk  = start && (num_steps != '0) && ({1'b0, num_steps} <= DEPTH_N);
    assign w_stepEnd  = w_tick && (r_durCnt == DUR_W'(1));
    assign w_lastStep = ({1'b0, r_stepIdx} == (r_numSteps - NSTEP_W'(1)));
    assign w_entry    = r_table[w_loadIdx];

    // Prescaler restarts on every step load and stays parked outside PLAY.
    assign w_tickClear = w_load || (r_state != ST_PLAY);

    seq_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .sysclk  (sysclk),
        .sysrst_n(sysrst_n),
        .i_clear (w_tickClear),
        .o_tick  (w_tick)
    );

    // State register for the playback FSM.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and step-load decisions. Stop beats everything while
    // playing; a step load in the last cycle of a step makes advance seamless.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadIdx   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_startOk) begin
                    w_stateNext = ST_PLAY;
                    w_load      = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_stateNext = ST_IDLE;
                end else if (w_stepEnd) begin
                    if (!w_lastStep) begin
                        w_load    = 1'b1;
                        w_loadIdx = r_stepIdx + IDX_W'(1);
                    end else if (loop_en) begin
                        w_load = 1'b1;
                    end else begin
                        w_stateNext = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Step table: written only while idle, so it never changes under playback.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= ENTRY_RESET;
            end
        end else if ((r_state == ST_IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_A)) begin
            r_table[wr_addr] <= '{mask: wr_mask, scale: wr_scale, dur: wr_dur};
        end
    end

    // Step count is captured at start so the sequence length is fixed per run.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_numSteps <= '0;
        end else if ((r_state == ST_IDLE) && w_startOk) begin
            r_numSteps <= num_steps;
        end
    end

    // Output registers and duration counter: loaded from the table at each
    // step load, counted down per tick, and zeroed whenever PLAY is left.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_enable  <= '0;
            r_scale   <= '0;
            r_stepIdx <= '0;
            r_durCnt  <= '0;
        end else if (w_load) begin
            r_enable  <= w_entry.mask;
            r_scale   <= w_entry.scale;
            r_stepIdx <= w_loadIdx;
            r_durCnt  <= effDur(w_entry.dur);
        end else if (w_stateNext != ST_PLAY) begin
            r_enable  <= '0;
            r_scale   <= '0;
            r_stepIdx <= '0;
            r_durCnt  <= '0;
        end else if (w_tick) begin
            r_durCnt <= r_durCnt - DUR_W'(1);
        end
    end

    assign Enable_SW = r_enable;
    assign Scale     = r_scale;
    assign step_idx  = r_stepIdx;
    assign busy      = (r_state == ST_PLAY);
    assign done      = (r_state == ST_DONE);
    assign wr_ready  = (r_state == ST_IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// ----------------------------------------------------------------------------
// tb_wave_sequencer
// Self-checking bench for wave_sequencer with TICK_DIV=4. A model table in the
// bench mirrors every accepted write; expected per-cycle output traces are
// expanded from that table (each step repeated max(dur,1)*4 cycles).
// ----------------------------------------------------------------------------
module tb_wave_sequencer;

    localparam int TICK  = 4;
    localparam int DEPTH = 8;

    logic       sysclk = 1'b0;
    logic       sysrst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_mask = '0;
    logic [5:0] wr_scale = '0;
    logic [7:0] wr_dur = '0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] num_steps = '0;
    logic [3:0] Enable_SW;
    logic [5:0] Scale;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    int testsRun = 0;
    int testsFailed = 0;

    // Model table
    logic [3:0] mdlMask  [DEPTH];
    logic [5:0] mdlScale [DEPTH];
    logic [7:0] mdlDur   [DEPTH];

    // Expected trace entries: {busy, done, idx[2:0], mask[3:0], scale[5:0]}
    logic [14:0] expQ [$];
    logic [14:0] obs;

    wave_sequencer #(
        .TICK_DIV(TICK),
        .DEPTH   (DEPTH)
    ) dut (
        .sysclk   (sysclk),
        .sysrst_n (sysrst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_scale (wr_scale),
        .wr_dur   (wr_dur),
        .wr_ready (wr_ready),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .num_steps(num_steps),
        .Enable_SW(Enable_SW),
        .Scale    (Scale),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    always #5 sysclk = ~sysclk;

    // Watchdog so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) begin
            mdlMask[i]  = 4'd0;
            mdlScale[i] = 6'd0;
            mdlDur[i]   = 8'd1;
        end
    endtask

    // Write one entry while the DUT is idle and mirror it in the model
    task automatic writeEntry(input int addr, input logic [3:0] m, input logic [5:0] s,
                              input logic [7:0] d);
        @(negedge sysclk);
        wr_en    = 1'b1;
        wr_addr  = 3'(addr);
        wr_mask  = m;
        wr_scale = s;
        wr_dur   = d;
        @(negedge sysclk);
        wr_en = 1'b0;
        mdlMask[addr]  = m;
        mdlScale[addr] = s;
        mdlDur[addr]   = d;
    endtask

    // Expand the model table into the expected per-cycle trace
    task automatic buildTrace(input int n, input int periods, input bit withDone);
        int len;
        expQ.delete();
        for (int p = 0; p < periods; p++) begin
            for (int s = 0; s < n; s++) begin
                len = ((mdlDur[s] == 8'd0) ? 1 : int'(mdlDur[s])) * TICK;
                for (int c = 0; c < len; c++) begin
                    expQ.push_back({1'b1, 1'b0, 3'(s), mdlMask[s], mdlScale[s]});
                end
            end
        end
        if (withDone) begin
            expQ.push_back({1'b0, 1'b1, 3'd0, 4'd0, 6'd0});
            expQ.push_back({1'b0, 1'b0, 3'd0, 4'd0, 6'd0});
        end
    endtask

    // Pulse start at the next negedge; returns at the negedge of the first
    // cycle after the accepting edge
    task automatic pulseStart(input logic [3:0] n);
        @(negedge sysclk);
        num_steps = n;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        sysrst_n = 1'b0;
        #12;
        testsRun++;
        if ({busy, done, Enable_SW, Scale, step_idx, wr_ready} !== {1'b0, 1'b0, 4'd0, 6'd0, 3'd0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: busy=%b done=%b en=%h scale=%0d idx=%0d rdy=%b, expected 0 0 0 0 0 1",
                     busy, done, Enable_SW, Scale, step_idx, wr_ready);
        end
        @(negedge sysclk);
        sysrst_n = 1'b1;
        resetModel();
        @(negedge sysclk);
    endtask

    task automatic test_basic();
        writeEntry(0, 4'b0001, 6'd32, 8'd2);
        writeEntry(1, 4'b0110, 6'd16, 8'd1);
        buildTrace(2, 1, 1'b1);
        pulseStart(4'd2);
        foreach (expQ[i]) begin
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL basic cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        buildTrace(2, 3, 1'b0);
        pulseStart(4'd2);
        foreach (expQ[i]) begin
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL loop cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        loop_en = 1'b0;
        testsRun++;
        if ({busy, done, Enable_SW, Scale} !== 12'd0) begin
            testsFailed++;
            $display("[TB] FAIL loop_stop: busy=%b done=%b en=%h scale=%0d, expected all 0",
                     busy, done, Enable_SW, Scale);
        end
        repeat (3) begin
            @(negedge sysclk);
            testsRun++;
            if ({busy, done} !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL loop_after_stop: busy=%b done=%b, expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_dur_zero();
        writeEntry(0, 4'b1010, 6'd5, 8'd0);
        buildTrace(1, 1, 1'b1);
        pulseStart(4'd1);
        foreach (expQ[i]) begin
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL dur_zero cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
    endtask

    task automatic test_write_during_play();
        writeEntry(0, 4'b0001, 6'd32, 8'd2);
        writeEntry(1, 4'b0110, 6'd16, 8'd1);
        buildTrace(2, 1, 1'b1);
        pulseStart(4'd2);
        // First playback: attempt to overwrite entry 1 mid-step (model unchanged)
        foreach (expQ[i]) begin
            if (i == 3) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 4'b1111; wr_scale = 6'd63; wr_dur = 8'd5;
                testsRun++;
                if (wr_ready !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL wr_ready_in_play: got %b expected 0", wr_ready);
                end
            end
            if (i == 4) wr_en = 1'b0;
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL wr_play_first cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
        // Replay must show the original entry 1
        pulseStart(4'd2);
        foreach (expQ[i]) begin
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL wr_play_replay cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
    endtask

    task automatic test_invalid_start();
        logic [3:0] bad [3];
        bad[0] = 4'd0; bad[1] = 4'd9; bad[2] = 4'd15;
        for (int k = 0; k < 3; k++) begin
            pulseStart(bad[k]);
            repeat (3) begin
                testsRun++;
                if ({busy, done, Enable_SW} !== 6'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL invalid_start n=%0d: busy=%b done=%b en=%h, expected 0 0 0",
                             bad[k], busy, done, Enable_SW);
                end
                @(negedge sysclk);
            end
        end
    endtask

    task automatic test_start_stop();
        pulseStart(4'd2);
        repeat (3) @(negedge sysclk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        stop  = 1'b0;
        testsRun++;
        if ({busy, done, Enable_SW, Scale} !== 12'd0) begin
            testsFailed++;
            $display("[TB] FAIL start_stop: busy=%b done=%b en=%h scale=%0d, expected all 0",
                     busy, done, Enable_SW, Scale);
        end
        @(negedge sysclk);
        testsRun++;
        if ({busy, done} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL start_stop_after: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        pulseStart(4'd2);
        repeat (3) @(negedge sysclk);
        #2;
        sysrst_n = 1'b0;
        #1;
        testsRun++;
        if ({busy, done, Enable_SW, Scale, step_idx} !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: busy=%b done=%b en=%h scale=%0d idx=%0d, expected all 0",
                     busy, done, Enable_SW, Scale, step_idx);
        end
        @(negedge sysclk);
        sysrst_n = 1'b1;
        resetModel();
        repeat (2) begin
            @(negedge sysclk);
            testsRun++;
            if ({busy, done, wr_ready} !== 3'b001) begin
                testsFailed++;
                $display("[TB] FAIL after_reset_idle: busy=%b done=%b rdy=%b, expected 0 0 1",
                         busy, done, wr_ready);
            end
        end
        buildTrace(2, 1, 1'b1);
        pulseStart(4'd2);
        foreach (expQ[i]) begin
            obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
            testsRun++;
            if (obs !== expQ[i]) begin
                testsFailed++;
                $display("[TB] FAIL default_table cycle %0d: got %h expected %h", i, obs, expQ[i]);
            end
            @(negedge sysclk);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                writeEntry(a, 4'($urandom), 6'($urandom), 8'($urandom_range(0, 3)));
            end
            n = $urandom_range(1, DEPTH);
            buildTrace(n, 1, 1'b1);
            pulseStart(4'(n));
            foreach (expQ[i]) begin
                obs = {busy, done, expQ[i][14] ? step_idx : 3'd0, Enable_SW, Scale};
                testsRun++;
                if (obs !== expQ[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL random it%0d n=%0d cycle %0d: got %h expected %h",
                             it, n, i, obs, expQ[i]);
                end
                @(negedge sysclk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_dur_zero();
        test_write_during_play();
        test_invalid_start();
        test_start_stop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
